// File: rtl/fns_coder_seq_if.sv
// Handshake bundle for the Fibonacci-number-system coder: input word
// with enable mask on one side, registered code word with error flag on the other.
interface fns_coder_seq_if #(
  parameter int CODE_W = 8,
  parameter int DATA_W = 6
);
  logic [DATA_W-1:0] datain;
  logic [CODE_W-1:0] en_flag;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] codeout;
  logic              err;
  logic              out_valid;
  logic              out_ready;

  // master is the producer/consumer around the coder; slave is the coder itself.
  modport master (
    output datain, en_flag, in_valid, out_ready,
    input  in_ready, codeout, err, out_valid
  );

  modport slave (
    input  datain, en_flag, in_valid, out_ready,
    output in_ready, codeout, err, out_valid
  );
endinterface

// File: rtl/fns_coder_seq.sv
// Sequential greedy Fibonacci-number-system encoder: one code bit per cycle,
// MSB first, skipping lines masked off by en_flag.
module fns_coder_seq #(
  parameter int CODE_W = 8,
  parameter int DATA_W = 6
) (
  input logic           clock,
  input logic           reset,
  fns_coder_seq_if.slave bus
);

  function automatic int unsigned fib_weight(input int unsigned k);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 1;
    for (int unsigned i = 2; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Remainder is wide enough for both the input word and the largest weight.
  localparam int unsigned W_TOP     = fib_weight(CODE_W - 1);
  localparam int          WTOP_BITS = $clog2(W_TOP + 1);
  localparam int          RW        = (DATA_W > WTOP_BITS) ? DATA_W : WTOP_BITS;
  localparam int          KW        = $clog2(CODE_W);
  localparam logic [KW-1:0] K_TOP   = KW'(CODE_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENC,
    S_DONE
  } state_e;

  logic [RW-1:0] weight [CODE_W];

  for (genvar g = 0; g < CODE_W; g++) begin : g_weight
    assign weight[g] = RW'(fib_weight(g));
  end

  state_e            state_q,   state_d;
  logic [RW-1:0]     r_q,       r_d;
  logic [CODE_W-1:0] mask_q,    mask_d;
  logic [CODE_W-1:0] code_q,    code_d;
  logic [KW-1:0]     k_q,       k_d;
  logic [CODE_W-1:0] codeout_q, codeout_d;
  logic              err_q,     err_d;

  logic              take;
  logic [RW-1:0]     r_next;
  logic [CODE_W-1:0] code_next;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    r_d       = r_q;
    mask_d    = mask_q;
    code_d    = code_q;
    k_d       = k_q;
    codeout_d = codeout_q;
    err_d     = err_q;
    take      = 1'b0;
    r_next    = r_q;
    code_next = code_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          r_d     = RW'(bus.datain);
          mask_d  = bus.en_flag;
          code_d  = '0;
          k_d     = K_TOP;
          state_d = S_ENC;
        end
      end

      S_ENC: begin
        take            = mask_q[k_q] && (r_q >= weight[k_q]);
        r_next          = take ? (r_q - weight[k_q]) : r_q;
        code_next[k_q]  = take;
        r_d             = r_next;
        code_d          = code_next;
        if (k_q == '0) begin
          codeout_d = code_next;
          err_d     = (r_next != '0);
          state_d   = S_DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its _d, independent of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      mask_q    <= '0;
      code_q    <= '0;
      k_q       <= K_TOP;
      codeout_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      mask_q    <= mask_d;
      code_q    <= code_d;
      k_q       <= k_d;
      codeout_q <= codeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.codeout   = codeout_q;
  assign bus.err       = err_q;

  // Handshake invariants; ignored by synthesis.
  a_ready_valid_exclusive : assert property (@(posedge clock)
    !(bus.in_ready && bus.out_valid));

  a_stall_holds_output : assert property (@(posedge clock) disable iff (reset)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.codeout) && $stable(bus.err)));

  a_index_in_range : assert property (@(posedge clock)
    k_q <= K_TOP);

endmodule

// File: tb/tb_fns_coder_seq.sv
// Self-checking bench for fns_coder_seq: directed vectors, randomized words
// against a greedy Fibonacci reference, stall, reset abort and back-to-back spacing.
module tb_fns_coder_seq;

  localparam int CODE_W = 8;
  localparam int DATA_W = 6;
  localparam int LAT    = CODE_W;
  localparam int GAP    = CODE_W + 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  fns_coder_seq_if #(.CODE_W(CODE_W), .DATA_W(DATA_W)) bus ();

  fns_coder_seq #(.CODE_W(CODE_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Greedy Fibonacci representation computed from the weight recurrence.
  function automatic void model(input int d, input logic [CODE_W-1:0] en,
                                output logic [CODE_W-1:0] code, output logic e);
    int w [CODE_W];
    int r;
    w[0] = 1;
    w[1] = 1;
    for (int k = 2; k < CODE_W; k++) w[k] = w[k-1] + w[k-2];
    r    = d;
    code = '0;
    for (int k = CODE_W - 1; k >= 0; k--) begin
      if (en[k] && r >= w[k]) begin
        code[k] = 1'b1;
        r       = r - w[k];
      end
    end
    e = (r != 0);
  endfunction

  // Present one word, scramble inputs after acceptance, count edges to out_valid,
  // capture the result and hand it off with a single out_ready pulse.
  task automatic run_word(input int d, input logic [CODE_W-1:0] en,
                          output logic [CODE_W-1:0] code, output logic e,
                          output int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.in_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    bus.datain    = DATA_W'(d);
    bus.en_flag   = en;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.datain   = DATA_W'($urandom);
    bus.en_flag  = CODE_W'($urandom);
    lat  = -1;
    code = 'x;
    e    = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.out_valid) begin
        lat  = c;
        code = bus.codeout;
        e    = bus.err;
        break;
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.datain    = DATA_W'(54);
    bus.en_flag   = '1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.codeout !== '0) begin
      failures++;
      $display("FAIL reset_codeout: got %h want 00", bus.codeout);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: got %b want 0", bus.err);
    end
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b want 1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    int               dv [5] = '{54, 20, 20, 2, 0};
    logic [CODE_W-1:0] ev [5] = '{8'hFF, 8'hFF, 8'hBF, 8'h01, 8'h00};
    logic [CODE_W-1:0] cv [5] = '{8'hFF, 8'h54, 8'h3F, 8'h01, 8'h00};
    logic              xv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [CODE_W-1:0] code;
    logic              e;
    int                lat;
    for (int i = 0; i < 5; i++) begin
      run_word(dv[i], ev[i], code, e, lat);
      checks++;
      if (code !== cv[i] || e !== xv[i]) begin
        failures++;
        $display("FAIL directed_%0d: got code=%h err=%b want code=%h err=%b",
                 i, code, e, cv[i], xv[i]);
      end
      checks++;
      if (lat != LAT) begin
        failures++;
        $display("FAIL directed_latency_%0d: got %0d want %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_random();
    logic [CODE_W-1:0] code, exp_code, en;
    logic              e, exp_e;
    int                d, lat;
    for (int i = 0; i < 40; i++) begin
      d  = int'($urandom_range(0, (1 << DATA_W) - 1));
      en = (i % 4 == 0) ? '1 : CODE_W'($urandom);
      model(d, en, exp_code, exp_e);
      run_word(d, en, code, e, lat);
      checks++;
      if (code !== exp_code || e !== exp_e || lat != LAT) begin
        failures++;
        $display("FAIL random_%0d d=%0d en=%h: got code=%h err=%b lat=%0d want code=%h err=%b lat=%0d",
                 i, d, en, code, e, lat, exp_code, exp_e, LAT);
      end
    end
  endtask

  task automatic test_stall();
    logic [CODE_W-1:0] exp_code;
    logic              exp_e;
    int                seen_valid;
    model(33, '1, exp_code, exp_e);
    @(negedge clock);
    bus.datain    = DATA_W'(33);
    bus.en_flag   = '1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 40 && !bus.out_valid; c++) @(negedge clock);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.codeout !== exp_code || bus.err !== exp_e) begin
        failures++;
        $display("FAIL stall_hold_%0d: got v=%b rdy=%b code=%h err=%b want v=1 rdy=0 code=%h err=%b",
                 c, bus.out_valid, bus.in_ready, bus.codeout, bus.err, exp_code, exp_e);
      end
      bus.in_valid = ~bus.in_valid;
      bus.datain   = DATA_W'($urandom);
      bus.en_flag  = CODE_W'($urandom);
      @(negedge clock);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    seen_valid = 0;
    repeat (GAP + 2) begin
      @(negedge clock);
      if (bus.out_valid) seen_valid++;
    end
    checks++;
    if (seen_valid != 0) begin
      failures++;
      $display("FAIL stall_no_phantom: got %0d valid cycles want 0", seen_valid);
    end
  endtask

  task automatic test_reset_abort();
    logic [CODE_W-1:0] code;
    logic              e;
    int                lat, seen_valid;
    @(negedge clock);
    bus.datain    = DATA_W'(54);
    bus.en_flag   = '1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    seen_valid = 0;
    repeat (GAP + 2) begin
      @(negedge clock);
      if (bus.out_valid) seen_valid++;
    end
    checks++;
    if (seen_valid != 0) begin
      failures++;
      $display("FAIL abort_no_output: got %0d valid cycles want 0", seen_valid);
    end
    bus.out_ready = 1'b0;
    run_word(20, '1, code, e, lat);
    checks++;
    if (code !== 8'h54 || e !== 1'b0 || lat != LAT) begin
      failures++;
      $display("FAIL abort_next_word: got code=%h err=%b lat=%0d want code=54 err=0 lat=%0d",
               code, e, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [CODE_W-1:0] exp_q [$];
    logic              err_q [$];
    int                acc_cyc [$];
    logic [CODE_W-1:0] ec;
    logic              ee;
    int                d;
    logic [CODE_W-1:0] en;
    int                outs;
    outs          = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_output: got code=%h with nothing in flight", bus.codeout);
        end else begin
          ec = exp_q.pop_front();
          ee = err_q.pop_front();
          if (bus.codeout !== ec || bus.err !== ee) begin
            failures++;
            $display("FAIL b2b_output_%0d: got code=%h err=%b want code=%h err=%b",
                     outs, bus.codeout, bus.err, ec, ee);
          end
        end
        outs++;
      end
      if (acc_cyc.size() < 4) begin
        d  = int'($urandom_range(0, (1 << DATA_W) - 1));
        en = CODE_W'($urandom) | 8'h81;
        bus.datain   = DATA_W'(d);
        bus.en_flag  = en;
        bus.in_valid = 1'b1;
        if (bus.in_ready) begin
          model(d, en, ec, ee);
          exp_q.push_back(ec);
          err_q.push_back(ee);
          acc_cyc.push_back(cyc);
        end
      end else begin
        bus.in_valid = 1'b0;
        if (exp_q.size() == 0) break;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (acc_cyc.size() != 4 || outs != 4) begin
      failures++;
      $display("FAIL b2b_count: got accepts=%0d outputs=%0d want 4/4", acc_cyc.size(), outs);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != GAP) begin
        failures++;
        $display("FAIL b2b_spacing_%0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], GAP);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.datain    = '0;
    bus.en_flag   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
